// File: rtl/nic_inject_sched.sv
// Injection scheduler: shares one flit link to the router between NUM_SRC packet
// sources, binding a VC per packet and enforcing per-VC credit flow control.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

module nic_inject_sched #(
  parameter int NUM_SRC    = 4,
  parameter int NUM_VC     = 2,
  parameter int BUF_DEPTH  = 4,
  parameter int FLIT_WIDTH = `FLIT_DATA_WIDTH,
  parameter int VC_W       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*FLIT_WIDTH-1:0] src_flit,
  input  logic [NUM_SRC-1:0]            src_head,
  input  logic [NUM_SRC-1:0]            src_tail,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic                          out_valid,
  output logic [FLIT_WIDTH-1:0]         out_flit,
  output logic [VC_W-1:0]               out_vc,
  output logic                          out_head,
  output logic                          out_tail,
  input  logic                          credit_valid,
  input  logic [VC_W-1:0]               credit_vc,
  output logic [NUM_VC-1:0]             vc_busy,
  output logic                          err
);

  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW    = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  logic [CW-1:0]      credit     [NUM_VC];
  logic [CW-1:0]      credit_nxt [NUM_VC];
  logic [NUM_SRC-1:0] bound;
  logic [VC_W-1:0]    bvc        [NUM_SRC];
  logic [SRC_W-1:0]   rr;

  logic               free_found;
  logic [VC_W-1:0]    free_vc;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] proto_err;
  logic               grant;
  logic [SRC_W-1:0]   winner;
  logic [VC_W-1:0]    gvc;
  logic               credit_full_err;

  // Descending scan so the lowest-index allocatable VC is the one kept.
  always_comb begin
    free_found = 1'b0;
    free_vc    = '0;
    for (int v = NUM_VC - 1; v >= 0; v--) begin
      if (!vc_busy[v] && credit[v] != '0) begin
        free_found = 1'b1;
        free_vc    = VC_W'(v);
      end
    end
  end

  always_comb begin
    elig      = '0;
    proto_err = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (src_valid[s]) begin
        if (bound[s]) begin
          proto_err[s] = src_head[s];
          elig[s]      = !src_head[s] && (credit[bvc[s]] != '0);
        end else begin
          proto_err[s] = !src_head[s];
          elig[s]      = src_head[s] && free_found;
        end
      end
    end
  end

  always_comb begin
    int idx;
    idx    = 0;
    grant  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = (int'(rr) + i) % NUM_SRC;
      if (!grant && elig[idx]) begin
        grant  = 1'b1;
        winner = SRC_W'(idx);
      end
    end
  end

  assign gvc       = bound[winner] ? bvc[winner] : free_vc;
  assign src_ready = (grant && reset) ? (NUM_SRC'(1) << winner) : '0;

  // A return that would overflow is dropped unless a same-cycle grant consumes a slot.
  assign credit_full_err = credit_valid && (credit[credit_vc] == FULL) &&
                           !(grant && gvc == credit_vc);

  always_comb begin
    logic dec;
    logic inc;
    dec = 1'b0;
    inc = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      credit_nxt[v] = credit[v];
      dec = grant && (gvc == VC_W'(v));
      inc = credit_valid && (credit_vc == VC_W'(v)) && !(credit[v] == FULL && !dec);
      if (dec && !inc)
        credit_nxt[v] = credit[v] - 1'b1;
      else if (inc && !dec)
        credit_nxt[v] = credit[v] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_flit  <= '0;
      out_vc    <= '0;
      out_head  <= 1'b0;
      out_tail  <= 1'b0;
      err       <= 1'b0;
      vc_busy   <= '0;
      bound     <= '0;
      rr        <= '0;
      for (int v = 0; v < NUM_VC; v++) credit[v] <= FULL;
      for (int s = 0; s < NUM_SRC; s++) bvc[s] <= '0;
    end else begin
      out_valid <= grant;
      if (grant) begin
        out_flit <= src_flit[int'(winner)*FLIT_WIDTH +: FLIT_WIDTH];
        out_vc   <= gvc;
        out_head <= src_head[winner];
        out_tail <= src_tail[winner];
        // Tail releases the binding; otherwise the packet holds its VC.
        if (src_tail[winner]) begin
          bound[winner] <= 1'b0;
          vc_busy[gvc]  <= 1'b0;
        end else begin
          bound[winner] <= 1'b1;
          bvc[winner]   <= gvc;
          vc_busy[gvc]  <= 1'b1;
        end
        rr <= (int'(winner) == NUM_SRC - 1) ? '0 : winner + 1'b1;
      end
      for (int v = 0; v < NUM_VC; v++) credit[v] <= credit_nxt[v];
      if (|proto_err || credit_full_err) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nic_inject_sched.sv
// Randomized bench for nic_inject_sched against a transaction-level model of
// sources, VC bindings, credit counts and a router that returns credits later.
module tb_nic_inject_sched;
  localparam int NS = 4;
  localparam int NV = 2;
  localparam int BD = 4;
  localparam int FW = 16;
  localparam int VW = 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [NS-1:0]    src_valid = '0;
  logic [NS*FW-1:0] src_flit = '0;
  logic [NS-1:0]    src_head = '0;
  logic [NS-1:0]    src_tail = '0;
  logic [NS-1:0]    src_ready;
  logic             out_valid;
  logic [FW-1:0]    out_flit;
  logic [VW-1:0]    out_vc;
  logic             out_head;
  logic             out_tail;
  logic             credit_valid = 1'b0;
  logic [VW-1:0]    credit_vc = '0;
  logic [NV-1:0]    vc_busy;
  logic             err;

  nic_inject_sched #(
    .NUM_SRC(NS), .NUM_VC(NV), .BUF_DEPTH(BD), .FLIT_WIDTH(FW), .VC_W(VW)
  ) dut (
    .clk(clk), .reset(reset),
    .src_valid(src_valid), .src_flit(src_flit), .src_head(src_head), .src_tail(src_tail),
    .src_ready(src_ready),
    .out_valid(out_valid), .out_flit(out_flit), .out_vc(out_vc),
    .out_head(out_head), .out_tail(out_tail),
    .credit_valid(credit_valid), .credit_vc(credit_vc),
    .vc_busy(vc_busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: what the router has room for and who owns which VC.
  int          m_credit [NV];
  bit          m_busy   [NV];
  bit          m_bound  [NS];
  int          m_bvc    [NS];
  int          m_rr;
  bit          m_err;
  bit          e_valid;
  logic [FW-1:0] e_flit;
  int          e_vc;
  bit          e_head, e_tail;
  int          inflight[$];

  int          gen_rem   [NS];
  bit          gen_first [NS];
  logic [FW-1:0] gen_data [NS];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int v = 0; v < NV; v++) begin m_credit[v] = BD; m_busy[v] = 0; end
    for (int s = 0; s < NS; s++) begin
      m_bound[s] = 0; m_bvc[s] = 0; gen_rem[s] = 0; gen_first[s] = 0; gen_data[s] = '0;
    end
    m_rr = 0; m_err = 0; e_valid = 0; e_flit = '0; e_vc = 0; e_head = 0; e_tail = 0;
    inflight.delete();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_out_valid"}, out_valid, 0);
    checkOutput({tag, "_out_flit"}, out_flit, 0);
    checkOutput({tag, "_out_vc"}, out_vc, 0);
    checkOutput({tag, "_out_head"}, out_head, 0);
    checkOutput({tag, "_out_tail"}, out_tail, 0);
    checkOutput({tag, "_err"}, err, 0);
    checkOutput({tag, "_vc_busy"}, vc_busy, 0);
    checkOutput({tag, "_src_ready"}, src_ready, 0);
  endtask

  // One clock cycle: drive, predict the grant, then predict the registered results.
  task automatic applyStimulus(input logic [NS-1:0] v, input logic [NS-1:0] h,
                               input logic [NS-1:0] t, input logic [NS*FW-1:0] f,
                               input bit cv, input int cvc, output int gw);
    int free;
    int vc;
    bit drop;
    bit perr;
    bit el [NS];
    logic [NS-1:0] exp_ready;
    logic [NV-1:0] exp_busy;
    @(negedge clk);
    src_valid = v; src_head = h; src_tail = t; src_flit = f;
    credit_valid = cv; credit_vc = VW'(cvc);
    free = -1;
    for (int k = 0; k < NV; k++)
      if (free < 0 && !m_busy[k] && m_credit[k] > 0) free = k;
    perr = 0;
    for (int s = 0; s < NS; s++) begin
      el[s] = 0;
      if (v[s]) begin
        if (m_bound[s] && h[s]) perr = 1;
        else if (!m_bound[s] && !h[s]) perr = 1;
        else if (m_bound[s]) el[s] = m_credit[m_bvc[s]] > 0;
        else el[s] = free >= 0;
      end
    end
    gw = -1;
    for (int i = 0; i < NS; i++)
      if (gw < 0 && el[(m_rr + i) % NS]) gw = (m_rr + i) % NS;
    exp_ready = (gw >= 0) ? NS'(1) << gw : '0;
    vc = (gw >= 0) ? (m_bound[gw] ? m_bvc[gw] : free) : -1;
    drop = cv && m_credit[cvc] == BD && vc != cvc;
    #1;
    checkOutput("src_ready", src_ready, exp_ready);
    @(posedge clk);
    if (gw >= 0) begin
      m_credit[vc]--;
      e_valid = 1; e_flit = f[gw*FW +: FW]; e_vc = vc; e_head = h[gw]; e_tail = t[gw];
      if (t[gw]) begin m_bound[gw] = 0; m_busy[vc] = 0; end
      else begin m_bound[gw] = 1; m_bvc[gw] = vc; m_busy[vc] = 1; end
      m_rr = (gw + 1) % NS;
      inflight.push_back(vc);
    end else begin
      e_valid = 0;
    end
    if (cv) begin
      if (drop) m_err = 1;
      else m_credit[cvc]++;
    end
    if (perr) m_err = 1;
    #1;
    checkOutput("out_valid", out_valid, e_valid);
    if (e_valid) begin
      checkOutput("out_flit", out_flit, e_flit);
      checkOutput("out_vc", out_vc, e_vc);
      checkOutput("out_head", out_head, e_head);
      checkOutput("out_tail", out_tail, e_tail);
    end
    for (int k = 0; k < NV; k++) exp_busy[k] = m_busy[k];
    checkOutput("vc_busy", vc_busy, exp_busy);
    checkOutput("err", err, m_err);
  endtask

  task automatic randomStep(input int ret_pct);
    logic [NS-1:0] v, h, t;
    logic [NS*FW-1:0] f;
    bit cv;
    int cvc;
    int gw;
    v = '0; h = '0; t = '0; f = '0; cv = 0; cvc = 0;
    for (int s = 0; s < NS; s++) begin
      if (gen_rem[s] == 0 && $urandom_range(99) < 40) begin
        gen_rem[s] = $urandom_range(1, 6);
        gen_first[s] = 1;
        gen_data[s] = FW'($urandom);
      end
      v[s] = gen_rem[s] > 0 && $urandom_range(99) < 85;
      h[s] = gen_first[s];
      t[s] = gen_rem[s] == 1;
      f[s*FW +: FW] = gen_data[s];
    end
    if (inflight.size() > 0 && $urandom_range(99) < ret_pct) begin
      cv = 1;
      cvc = inflight.pop_front();
    end
    applyStimulus(v, h, t, f, cv, cvc, gw);
    if (gw >= 0) begin
      gen_rem[gw]--;
      gen_first[gw] = 0;
      gen_data[gw] = FW'($urandom);
    end
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    src_valid = '1; src_head = '1; src_tail = '0; credit_valid = 1'b0;
    #1;
    checkResetOutputs(tag);
    @(posedge clk);
    @(negedge clk);
    modelReset();
    src_valid = '0;
    reset = 1'b1;
  endtask

  initial begin
    int gw;
    int pct [6] = '{80, 30, 5, 100, 50, 0};
    modelReset();
    src_valid = 4'b0001; src_head = 4'b0001;
    #2;
    checkResetOutputs("por");
    @(negedge clk);
    src_valid = '0;
    reset = 1'b1;

    for (int c = 0; c < 3000; c++) randomStep(pct[(c / 250) % 6]);

    doReset("midpkt");
    applyStimulus(4'b0010, 4'b0000, 4'b0000, '0, 0, 0, gw);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, '0, 0, 0, gw);

    doReset("rst2");
    applyStimulus(4'b0000, 4'b0000, 4'b0000, '0, 1, 0, gw);
    for (int k = 0; k < 5; k++)
      applyStimulus(4'b0001, (k == 0) ? 4'b0001 : 4'b0000, 4'b0000, 64'(k + 16'h100), 0, 0, gw);
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 64'h155, 1, 0, gw);
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 64'h155, 0, 0, gw);
    applyStimulus(4'b0001, 4'b0000, 4'b0001, 64'h166, 0, 0, gw);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
